// File: rtl/load_store_unit.sv
// Load/store responder: one request at a time, word-aligned bus transaction with byte lanes,
// extended load data or store completion back to writeback. Build option: LOAD_STORE_MISALIGN_TRAP_EN.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read_enable,
   input  logic        mem_write_enable,
   input  logic [2:0]  load_operation,
   input  logic [2:0]  store_operation,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   input  logic [4:0]  reg_write_address,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_byte_en,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        resp_valid,
   output logic        resp_reg_write_enable,
   output logic [4:0]  resp_reg_write_address,
   output logic [31:0] resp_load_data,
   output logic        resp_error
);

   // state | meaning
   // IDLE  | ready, accepts and decodes a request
   // BUS   | bus transaction outstanding, waiting for bus_ack or timeout
   // RESP  | one-cycle response pulse to writeback
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT_CYCLES);
   localparam bit         TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   state_t      state;
   logic [7:0]  counter;
   logic        is_load;
   logic [2:0]  funct;
   logic [1:0]  lane;
   logic [4:0]  rd;

   logic [1:0]  req_size;
   logic        op_valid;
   logic        misaligned;
   logic        req_bad;
   logic [3:0]  req_byte_en;
   logic [31:0] req_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [7:0]  counter_next;
   logic        timeout_hit;

   always_comb begin
      req_size = mem_read_enable ? load_operation[1:0] : store_operation[1:0];
      if (mem_read_enable)
         op_valid = load_operation inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      else
         op_valid = store_operation inside {3'b000, 3'b001, 3'b010};
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
      misaligned = (req_size == 2'b01 && address[0]) ||
                   (req_size == 2'b10 && address[1:0] != 2'b00);
`else
      misaligned = 1'b0;
`endif
      req_bad = (mem_read_enable && mem_write_enable) || !op_valid || misaligned;
      case (req_size)
         2'b00: begin
            req_byte_en = 4'b0001 << address[1:0];
            req_wdata   = {4{store_data[7:0]}};
         end
         2'b01: begin
            // without the trap build, address[0] is simply ignored for halves
            req_byte_en = address[1] ? 4'b1100 : 4'b0011;
            req_wdata   = {2{store_data[15:0]}};
         end
         default: begin
            req_byte_en = 4'b1111;
            req_wdata   = store_data;
         end
      endcase
   end

   always_comb begin
      ld_byte = bus_rdata[{lane, 3'b000} +: 8];
      ld_half = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (funct)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = bus_rdata;
      endcase
      counter_next = counter + 8'd1;
      timeout_hit  = TIMEOUT_EN && (counter_next == TIMEOUT_TC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                  <= IDLE;
         counter                <= 8'd0;
         is_load                <= 1'b0;
         funct                  <= 3'd0;
         lane                   <= 2'd0;
         rd                     <= 5'd0;
         req_ready              <= 1'b1;
         bus_req                <= 1'b0;
         bus_we                 <= 1'b0;
         bus_addr               <= 32'd0;
         bus_wdata              <= 32'd0;
         bus_byte_en            <= 4'd0;
         resp_valid             <= 1'b0;
         resp_reg_write_enable  <= 1'b0;
         resp_reg_write_address <= 5'd0;
         resp_load_data         <= 32'd0;
         resp_error             <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && (mem_read_enable || mem_write_enable)) begin
                  is_load   <= mem_read_enable;
                  funct     <= load_operation;
                  lane      <= address[1:0];
                  rd        <= reg_write_address;
                  req_ready <= 1'b0;
                  if (req_bad) begin
                     state                  <= RESP;
                     resp_valid             <= 1'b1;
                     resp_error             <= 1'b1;
                     resp_reg_write_enable  <= 1'b0;
                     resp_load_data         <= 32'd0;
                     resp_reg_write_address <= reg_write_address;
                  end else begin
                     state       <= BUS;
                     counter     <= 8'd0;
                     bus_req     <= 1'b1;
                     bus_we      <= mem_write_enable;
                     bus_addr    <= {address[31:2], 2'b00};
                     bus_wdata   <= req_wdata;
                     bus_byte_en <= req_byte_en;
                  end
               end
            end
            BUS: begin
               if (bus_ack || timeout_hit) begin
                  state                  <= RESP;
                  counter                <= 8'd0;
                  bus_req                <= 1'b0;
                  bus_we                 <= 1'b0;
                  resp_valid             <= 1'b1;
                  resp_error             <= !bus_ack;
                  resp_reg_write_enable  <= is_load && bus_ack;
                  resp_load_data         <= (is_load && bus_ack) ? ld_data : 32'd0;
                  resp_reg_write_address <= rd;
               end else begin
                  counter <= counter_next;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               bus_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written reset/stray-ack sequences,
// and randomized requests checked against a byte-level reference model.
module tb_load_store_unit;

   localparam int TO = 16;
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        mem_read_enable = 1'b0;
   logic        mem_write_enable = 1'b0;
   logic [2:0]  load_operation = 3'd0;
   logic [2:0]  store_operation = 3'd0;
   logic [31:0] address = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic [4:0]  reg_write_address = 5'd0;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_byte_en;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        resp_valid;
   logic        resp_reg_write_enable;
   logic [4:0]  resp_reg_write_address;
   logic [31:0] resp_load_data;
   logic        resp_error;

   int n_cmp = 0;
   int n_err = 0;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
      .load_operation(load_operation), .store_operation(store_operation),
      .address(address), .store_data(store_data), .reg_write_address(reg_write_address),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_byte_en(bus_byte_en), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .resp_valid(resp_valid), .resp_reg_write_enable(resp_reg_write_enable),
      .resp_reg_write_address(resp_reg_write_address), .resp_load_data(resp_load_data),
      .resp_error(resp_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd_en;
      logic        wr_en;
      logic [2:0]  lop;
      logic [2:0]  sop;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          ack_delay;
      logic        nobus;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] data;
      logic        err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: access of nb bytes at offset addr%4 rounded down to nb, unless trapping.
   function automatic vec_t model(input vec_t v);
      vec_t   e;
      int     f, nb, off;
      logic   ok, misal, tmo;
      logic [31:0] w;
      e  = v;
      f  = v.rd_en ? int'(v.lop) : int'(v.sop);
      ok = v.rd_en ? (f == 0 || f == 1 || f == 2 || f == 4 || f == 5) : (f <= 2);
      nb = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
      off = int'(v.addr % 4);
      misal = (off % nb) != 0;
      e.nobus = (v.rd_en && v.wr_en) || !ok || (TRAP && misal);
      off = off - (off % nb);
      e.be = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = v.sd[8*(i % nb) +: 8];
      w = v.rdata >> (8 * off);
      if (nb == 1)      w = (f < 4 && w[7])  ? (w | 32'hFFFFFF00) : (w & 32'h000000FF);
      else if (nb == 2) w = (f < 4 && w[15]) ? (w | 32'hFFFF0000) : (w & 32'h0000FFFF);
      tmo    = !e.nobus && (v.ack_delay < 0 || v.ack_delay >= TO);
      e.err  = e.nobus || tmo;
      e.data = (v.rd_en && !e.err) ? w : 32'd0;
      return e;
   endfunction

   // Entered and left at a negedge with the DUT idle.
   task automatic do_txn(input string tag, input vec_t v);
      int   n;
      logic acked;
      chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
      mem_read_enable   = v.rd_en;
      mem_write_enable  = v.wr_en;
      load_operation    = v.lop;
      store_operation   = v.sop;
      address           = v.addr;
      store_data        = v.sd;
      reg_write_address = v.rd;
      req_valid         = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      if (!v.rd_en && !v.wr_en) begin
         chk({tag, " dropped bus_req"}, 32'(bus_req), 32'd0);
         chk({tag, " dropped resp_valid"}, 32'(resp_valid), 32'd0);
         chk({tag, " dropped req_ready"}, 32'(req_ready), 32'd1);
         return;
      end
      if (!v.nobus) begin
         n = 0;
         acked = 1'b0;
         while (1) begin
            chk($sformatf("%s bus_req c%0d", tag, n), 32'(bus_req), 32'd1);
            chk($sformatf("%s bus_addr c%0d", tag, n), bus_addr, v.addr & 32'hFFFF_FFFC);
            chk($sformatf("%s bus_byte_en c%0d", tag, n), 32'(bus_byte_en), 32'(v.be));
            chk($sformatf("%s bus_we c%0d", tag, n), 32'(bus_we), 32'(v.wr_en));
            if (v.wr_en) chk($sformatf("%s bus_wdata c%0d", tag, n), bus_wdata, v.wdata);
            chk($sformatf("%s resp_valid early c%0d", tag, n), 32'(resp_valid), 32'd0);
            if (n == v.ack_delay) begin
               bus_ack   = 1'b1;
               bus_rdata = v.rdata;
               acked     = 1'b1;
            end else begin
               bus_rdata = $urandom;
            end
            @(posedge clk); #1;
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            @(negedge clk);
            if (acked) break;
            n++;
            if (n == TO) break;
         end
      end
      chk({tag, " bus_req at resp"}, 32'(bus_req), 32'd0);
      chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " resp_error"}, 32'(resp_error), 32'(v.err));
      chk({tag, " resp_we"}, 32'(resp_reg_write_enable), 32'(v.rd_en && !v.err));
      if (v.rd_en || v.err) chk({tag, " resp_load_data"}, resp_load_data, v.data);
      if (v.rd_en && !v.err) chk({tag, " resp_rd"}, 32'(resp_reg_write_address), 32'(v.rd));
      @(negedge clk);
      chk({tag, " resp_valid pulse end"}, 32'(resp_valid), 32'd0);
      chk({tag, " req_ready after"}, 32'(req_ready), 32'd1);
   endtask

   task automatic stray_ack(input string tag);
      bus_ack   = 1'b1;
      bus_rdata = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("%s resp_valid %0d", tag, i), 32'(resp_valid), 32'd0);
         chk($sformatf("%s bus_req %0d", tag, i), 32'(bus_req), 32'd0);
      end
      bus_ack = 1'b0;
      @(negedge clk);
   endtask

   vec_t vecs[16];
   vec_t r;

   initial begin
      vecs[0]  = '{1, 0, 3'b010, 3'b000, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0};
      vecs[1]  = '{1, 0, 3'b000, 3'b000, 32'h103, 32'h0, 5'd6, 32'h80112233, 0, 0, 4'h8, 32'h0, 32'hFFFFFF80, 0};
      vecs[2]  = '{1, 0, 3'b100, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80112233, 0, 0, 4'h8, 32'h0, 32'h00000080, 0};
      vecs[3]  = '{1, 0, 3'b101, 3'b000, 32'h102, 32'h0, 5'd8, 32'h80112233, 0, 0, 4'hC, 32'h0, 32'h00008011, 0};
      vecs[4]  = '{0, 1, 3'b000, 3'b000, 32'h201, 32'hA5, 5'd0, 32'h0, 0, 0, 4'h2, 32'hA5A5A5A5, 32'h0, 0};
      vecs[5]  = '{1, 1, 3'b010, 3'b010, 32'h100, 32'h0, 5'd9, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0, 1};
      vecs[6]  = '{1, 0, 3'b011, 3'b000, 32'h100, 32'h0, 5'd10, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0, 1};
`ifdef LOAD_STORE_MISALIGN_TRAP_EN
      vecs[7]  = '{1, 0, 3'b010, 3'b000, 32'h102, 32'h0, 5'd11, 32'hCAFEF00D, 0, 1, 4'h0, 32'h0, 32'h0, 1};
`else
      vecs[7]  = '{1, 0, 3'b010, 3'b000, 32'h102, 32'h0, 5'd11, 32'hCAFEF00D, 0, 0, 4'hF, 32'h0, 32'hCAFEF00D, 0};
`endif
      vecs[8]  = '{1, 0, 3'b001, 3'b000, 32'h100, 32'h0, 5'd12, 32'h1234F678, 3, 0, 4'h3, 32'h0, 32'hFFFFF678, 0};
      vecs[9]  = '{0, 1, 3'b000, 3'b010, 32'h104, 32'h11223344, 5'd0, 32'h0, 1, 0, 4'hF, 32'h11223344, 32'h0, 0};
      vecs[10] = '{0, 1, 3'b000, 3'b001, 32'h206, 32'hABCD8765, 5'd0, 32'h0, 0, 0, 4'hC, 32'h87658765, 32'h0, 0};
      vecs[11] = '{0, 1, 3'b000, 3'b011, 32'h200, 32'h0, 5'd0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0, 1};
      vecs[12] = '{1, 0, 3'b001, 3'b000, 32'h102, 32'h0, 5'd13, 32'h80112233, 2, 0, 4'hC, 32'h0, 32'hFFFF8011, 0};
      vecs[13] = '{1, 0, 3'b100, 3'b000, 32'h101, 32'h0, 5'd14, 32'h80112233, 0, 0, 4'h2, 32'h0, 32'h00000022, 0};
      vecs[14] = '{0, 0, 3'b010, 3'b010, 32'h100, 32'h0, 5'd15, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0};
      vecs[15] = '{1, 0, 3'b010, 3'b000, 32'h300, 32'h0, 5'd16, 32'h0, -1, 0, 4'hF, 32'h0, 32'h0, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset bus_req", 32'(bus_req), 32'd0);
      chk("reset bus_addr", bus_addr, 32'd0);
      chk("reset bus_byte_en", 32'(bus_byte_en), 32'd0);
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset resp_load_data", resp_load_data, 32'd0);
      chk("reset resp_error", 32'(resp_error), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) do_txn($sformatf("vec%0d", i), vecs[i]);
      stray_ack("stray after timeout");

      // reset while a load is on the bus
      mem_read_enable  = 1'b1;
      mem_write_enable = 1'b0;
      load_operation   = 3'b010;
      address          = 32'h400;
      req_valid        = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("midrst bus_req before", 32'(bus_req), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst bus_req", 32'(bus_req), 32'd0);
      chk("midrst req_ready", 32'(req_ready), 32'd1);
      chk("midrst resp_valid", 32'(resp_valid), 32'd0);
      stray_ack("stray after reset");

      for (int i = 0; i < 200; i++) begin
         int sel;
         sel = int'($urandom_range(0, 9));
         r.rd_en     = (sel == 1) || (sel >= 2 && sel <= 5);
         r.wr_en     = (sel == 1) || (sel >= 6);
         r.lop       = 3'($urandom_range(0, 5));
         r.sop       = 3'($urandom_range(0, 3));
         r.addr      = $urandom;
         r.sd        = $urandom;
         r.rd        = 5'($urandom);
         r.rdata     = $urandom;
         r.ack_delay = ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, 3));
         do_txn($sformatf("rnd%0d", i), model(r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the load/store commands the instruction decoder emits: mem_read_enable/mem_write_enable, load_operation/store_operation (funct3) and destination register.
- Takes one request at a time with an ALU-computed byte address. Runs a word-aligned bus transaction with byte enables.
- Returns sign/zero-extended load data or store completion to the register-writeback stage.

Parameters:
- TIMEOUT_CYCLES, 16: bus cycles to wait for bus_ack before an error response; 0 disables the timeout.
- Width of TIMEOUT_CYCLES counter: 8, covers TIMEOUT_CYCLES up to 255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- mem_read_enable  in  1  load request
- mem_write_enable  in  1  store request
- load_operation  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- store_operation  in  3  funct3: 000 SB, 001 SH, 010 SW
- address  in  32  byte address (rs1 + imm)
- store_data  in  32  rs2 value
- reg_write_address  in  5  load destination register
- bus_req  out  1  bus transaction active
- bus_we  out  1  1 = write
- bus_addr  out  32  {address[31:2], 2'b00}
- bus_wdata  out  32  store data lane-shifted
- bus_byte_en  out  4  active byte lanes
- bus_ack  in  1  transaction complete
- bus_rdata  in  32  read word, valid with bus_ack
- resp_valid  out  1  one-cycle completion pulse
- resp_reg_write_enable  out  1  1 for a successful load
- resp_reg_write_address  out  5  destination register
- resp_load_data  out  32  extended load result
- resp_error  out  1  bad funct3, conflicting enables, timeout or misalignment

Behaviour:
- Reset (rst high at a clk edge): state IDLE; req_ready=1; bus_req, bus_we, resp_valid, resp_reg_write_enable and resp_error = 0; bus_addr, bus_wdata, resp_load_data = 0; bus_byte_en=0; resp_reg_write_address=0; counter=0.
- Reset mid-transaction aborts it. A bus_ack arriving later is ignored in IDLE.
- FSM states: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid, the request is accepted and latched.
  - Neither enable set: request dropped, no response, stay IDLE.
  - Both enables set, or invalid funct3: go to RESP with error=1 and no bus cycle.
  - Otherwise go to BUS.
- BUS: req_ready=0; bus_req=1 with bus_addr, bus_we, bus_wdata and bus_byte_en held stable until bus_ack.
  - On bus_ack: latch bus_rdata, go to RESP.
  - The counter increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0), drop bus_req and go to RESP with error=1.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No backpressure.
  - resp_reg_write_enable = load && !error.
  - Other resp_* outputs hold their values until the next RESP.
- Latency: accept edge, then BUS for at least 1 cycle, then RESP. With same-cycle ack, resp_valid is asserted 2 cycles after acceptance. Minimum request interval is 3 cycles.
- Lane selection (a = address[1:0]):
  - Byte: bus_byte_en = 0001<<a; bus_wdata = {4{store_data[7:0]}}.
  - Half: bus_byte_en = 0011<<(a[1]*2); bus_wdata = {2{store_data[15:0]}}.
  - Word: bus_byte_en = 1111; bus_wdata = store_data.
- Loads: pick the byte at bus_rdata[8a+7:8a], or the half at bus_rdata[16a[1]+15:16a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - The bus read uses the same byte_en pattern.
- Error response: resp_load_data=0, resp_reg_write_enable=0.

Optional Feature:
- Macro LOAD_STORE_MISALIGN_TRAP_EN.
- Defined: a half access with address[0]=1, or a word access with address[1:0]!=0, gets no bus cycle and goes IDLE to RESP with resp_error=1.
- Undefined: the low address bits that break alignment are ignored (half uses address[1] only; word uses lanes 1111), and the access proceeds normally.

Test Plan:
- LW at 0x100, bus_rdata=0xDEADBEEF with ack in the first BUS cycle: bus_addr=0x100, bus_byte_en=1111, resp_valid 2 cycles after accept, resp_load_data=0xDEADBEEF, resp_reg_write_enable=1, rd echoed.
- LB at 0x103 with rdata=0x80112233: byte_en=1000, data=0xFFFFFF80. LBU, same stimulus: data=0x00000080. LHU at 0x102: data=0x00008011.
- SB store_data=0x000000A5 at 0x201: bus_we=1, bus_addr=0x200, byte_en=0010, wdata=0xA5A5A5A5, resp_valid with reg_write_enable=0 and error=0.
- No ack for 16 BUS cycles (TIMEOUT_CYCLES=16): bus_req drops, resp_error=1, back to IDLE with req_ready=1. A stray ack afterwards produces no response.
- Both enables set, or load_operation=011: no bus_req, resp_error=1 one cycle after accept. rst asserted during BUS: bus_req=0 and req_ready=1 the cycle after.
- With the macro defined, LW at 0x102: resp_error=1, no bus_req. Without the macro: bus_addr=0x100, byte_en=1111, normal response.
